// File: rtl/arp_sample_sequencer.sv
// arp_sample_sequencer: wavetable address/sample sequencer with a four-note arpeggiator
module arp_sample_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 11,
  parameter int BASE_OFFSET = 746,
  parameter int NOTE_HOLD   = 25_000_000
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic [7:0]        SW,
  input  logic              arp_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic [1:0]        note
);
  localparam int HW = $clog2(NOTE_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(NOTE_HOLD - 1);
  typedef enum logic [1:0] {NOTE0, NOTE1, NOTE2, NOTE3} note_t;
  note_t         note_q;
  logic [HW-1:0] hold_cnt;
  logic [9:0]    p_base, period, period_next, div_cnt;
  logic [10:0]   mult;
  logic [20:0]   product;
  logic          tick;
  assign p_base = 10'(BASE_OFFSET) + 10'(SW);
  always_comb begin
    mult = note_q == NOTE0 ? 11'd1024 : note_q == NOTE1 ? 11'd819 : note_q == NOTE2 ? 11'd683 : 11'd512;
    product = 21'(p_base) * 21'(mult);
    period_next = 10'(product >> 10);
  end
  // a zero period only exists in the first clock after reset, before any period is computed
  assign tick = period != '0 && div_cnt >= period - 10'd1;
  assign note = note_q;
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      mem_addr <= '0;
      sample <= '0;
      sample_valid <= 1'b0;
      note_q <= NOTE0;
      hold_cnt <= '0;
      div_cnt <= '0;
      period <= '0;
    end else begin
      period <= period_next;
      div_cnt <= (tick || period == '0) ? '0 : div_cnt + 10'd1;
      sample_valid <= tick;
      if (tick) begin
        sample <= mem_data;
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (!arp_en) begin
        hold_cnt <= '0;
        note_q <= NOTE0;
      end else if (hold_cnt == HOLD_LAST) begin
        hold_cnt <= '0;
        note_q <= note_t'(note_q + 2'd1);
      end else
        hold_cnt <= hold_cnt + HW'(1);
    end
endmodule

// File: tb/tb_arp_sample_sequencer.sv
// tb_arp_sample_sequencer: directed timing scenarios plus random stimulus against a time-based reference model
module tb_arp_sample_sequencer;
  localparam int NH = 5000;
  localparam int BASE = 746;
  localparam int FAST_BASE = 24;
  logic clk = 0, rst_n = 0, arp_en = 0;
  logic [7:0] sw = 0;
  logic [7:0] addr;
  logic [10:0] mem_data, sample;
  logic sample_valid;
  logic [1:0] note;
  logic [7:0] f_addr, f_sw = 0;
  logic [10:0] f_data, f_sample;
  logic f_valid, f_arp = 0;
  logic [1:0] f_note;
  int n_checks = 0, n_errs = 0, cyc = 0;
  int m_e, m_last, m_period, m_addr, m_sample, m_arpt;
  bit m_valid;
  int fn = 0, fn_max = 0;
  int mt[4] = '{1024, 819, 683, 512};
  int iv[4] = '{746, 596, 497, 373};

  always #5 clk = ~clk;

  function automatic logic [10:0] rom(input logic [7:0] a);
    return 11'((int'(a) * 7) % 2048);
  endfunction

  always @(posedge clk) mem_data <= rom(addr);
  always @(posedge clk) f_data <= rom(f_addr);
  always @(posedge clk) cyc <= cyc + 1;

  arp_sample_sequencer #(.NOTE_HOLD(NH)) u_dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .SW(sw), .arp_en(arp_en),
    .mem_addr(addr), .mem_data(mem_data), .sample(sample),
    .sample_valid(sample_valid), .note(note)
  );

  // short-period copy so the 256-entry address wrap is reachable quickly
  arp_sample_sequencer #(.BASE_OFFSET(FAST_BASE), .NOTE_HOLD(NH)) u_fast (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .SW(f_sw), .arp_en(f_arp),
    .mem_addr(f_addr), .mem_data(f_data), .sample(f_sample),
    .sample_valid(f_valid), .note(f_note)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // note is elapsed enabled time divided into NOTE_HOLD slices
  function automatic int mnote();
    return (m_arpt / NH) % 4;
  endfunction

  // ticks fire once the edges elapsed since the previous tick reach the current period
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_e <= 0; m_last <= 0; m_period <= 0; m_addr <= 0;
      m_sample <= 0; m_valid <= 0; m_arpt <= 0;
    end else begin
      m_e <= m_e + 1;
      if (m_period == 0) begin
        m_last <= m_e + 1;
        m_valid <= 0;
      end else if (m_e + 1 - m_last >= m_period) begin
        m_last <= m_e + 1;
        m_valid <= 1;
        m_sample <= rom(8'(m_addr));
        m_addr <= (m_addr + 1) % 256;
      end else
        m_valid <= 0;
      m_period <= ((BASE + sw) * mt[mnote()]) >> 10;
      m_arpt <= arp_en ? m_arpt + 1 : 0;
    end

  always @(posedge clk) begin
    #2;
    check("addr", addr, m_addr);
    check("sample", sample, m_sample);
    check("valid", sample_valid, m_valid);
    check("note", note, mnote());
  end

  always @(posedge clk) begin
    #2;
    if (!rst_n) fn = 0;
    else if (f_valid) begin
      fn++;
      check("wrap_addr", f_addr, fn % 256);
      check("wrap_sample", f_sample, rom(8'((fn - 1) % 256)));
      if (fn > fn_max) fn_max = fn;
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (!sample_valid && n < 2000);
    check("tick_seen", sample_valid, 1);
  endtask

  task automatic wait_note(input int k);
    int t = 0;
    do begin
      @(posedge clk); #2; t++;
    end while (note != 2'(k) && t < 6000);
    check("note_reach", note, k);
  endtask

  initial begin
    int n, a0, c0;
    repeat (10) begin
      @(negedge clk) sw = 8'($urandom);
      @(posedge clk); #2;
      check("rst_addr", addr, 0);
      check("rst_sample", sample, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_note", note, 0);
    end
    @(negedge clk) begin sw = 0; rst_n = 1; end
    wait_tick(n); check("first_tick", n, 747); check("addr1", addr, 1);
    wait_tick(n); check("steady", n, 746); check("addr2", addr, 2);
    @(negedge clk) sw = 255;
    wait_tick(n);
    wait_tick(n); check("sw255_iv", n, 1001);
    repeat (900) @(posedge clk);
    @(negedge clk) sw = 0;
    wait_tick(n); check("shrink_tick", n, 2);
    wait_tick(n); check("shrink_next", n, 746);
    @(negedge clk) begin arp_en = 1; c0 = cyc; end
    for (int k = 1; k <= 4; k++) begin
      wait_note(k % 4);
      check("hold", cyc - c0, NH);
      c0 = cyc;
      wait_tick(n);
      wait_tick(n); check("arp_iv", n, iv[k % 4]);
    end
    @(negedge clk) sw = 255;
    wait_note(1);
    wait_note(2);
    wait_tick(n);
    wait_tick(n); check("n2_sw255_iv", n, 667);
    @(negedge clk) begin arp_en = 0; sw = 0; end
    @(posedge clk); #2;
    check("dis_note", note, 0);
    a0 = addr;
    wait_tick(n);
    wait_tick(n); check("dis_iv", n, 746);
    check("dis_addr", addr, (a0 + 2) % 256);
    @(negedge clk) begin arp_en = 1; c0 = cyc; end
    wait_note(1); check("reen_hold", cyc - c0, NH);
    wait_note(2);
    wait_note(3);
    wait_tick(n);
    repeat (200) @(posedge clk);
    check("pre_rst_note", note, 3);
    #3 rst_n = 0;
    #1;
    check("arst_addr", addr, 0);
    check("arst_sample", sample, 0);
    check("arst_valid", sample_valid, 0);
    check("arst_note", note, 0);
    arp_en = 0;
    repeat (10) @(negedge clk);
    rst_n = 1;
    wait_tick(n); check("re_first_tick", n, 747); check("re_addr1", addr, 1);
    wait_tick(n); check("re_steady", n, 746);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sw = 8'($urandom);
      arp_en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(100, 800)) @(posedge clk);
    end
    check("wrap_reached", int'(fn_max >= 260), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
